if_fetch: RTL

- Instruction-fetch (IF) stage. Owns the program counter and drives the instruction-memory request/acknowledge handshake.
- Produces the PC/instruction pair that the IF/ID pipeline register latches.
- Absorbs memory wait states through a stall request, and handles branch redirects (preserving the delay slot) and exception flushes.

---
 rtl/if_fetch.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/if_fetch.sv
// Instruction-fetch stage: owns the PC, runs the imem request/ack handshake and
// hands PC/instruction pairs to IF/ID, absorbing wait states, branches and flushes.
package if_fetch_pkg;
  typedef logic reset_status_t;
  localparam reset_status_t RST_ENABLE  = 1'b1;
  localparam reset_status_t RST_DISABLE = 1'b0;
endpackage

module if_fetch
  import if_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned PC_STEP  = 4
) (
  input  logic          clk,
  input  reset_status_t rst,
  input  logic [5:0]    stall,
  input  logic          flush,
  input  logic [31:0]   new_pc,
  input  logic          branch_flag_i,
  input  logic [31:0]   branch_target_i,
  output logic          imem_req,
  output logic [31:0]   imem_addr,
  input  logic          imem_ack,
  input  logic [31:0]   imem_rdata,
  output logic [31:0]   if_pc_o,
  output logic [31:0]   if_inst_o,
  output logic          stallreq_if
);

  localparam logic [1:0] ST_RST = 2'd0;
  localparam logic [1:0] ST_REQ = 2'd1;
  localparam logic [1:0] ST_BUF = 2'd2;

  logic [1:0]  state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        pend_br_q, pend_br_d;
  logic [31:0] br_pc_q, br_pc_d;
  logic        pend_fl_q, pend_fl_d;
  logic [31:0] fl_pc_q, fl_pc_d;
  logic [31:0] inst_buf_q, inst_buf_d;

  logic        br_q;
  logic        discard;
  logic [31:0] pc_next;

  logic unused_stall;
  assign unused_stall = ^{stall[5:3], stall[1]};

  assign br_q    = branch_flag_i & ~stall[2];
  assign discard = pend_fl_q | flush;
  // A branch seen now wins over one remembered from earlier; either way the
  // instruction delivered alongside it is the delay slot and is kept.
  assign pc_next = br_q      ? branch_target_i :
                   pend_br_q ? br_pc_q         :
                               pc_q + 32'(PC_STEP);

  always_comb begin
    // NOTE: every signal gets a default first so no path infers a latch.
    state_d    = state_q;
    pc_d       = pc_q;
    pend_br_d  = pend_br_q;
    br_pc_d    = br_pc_q;
    pend_fl_d  = pend_fl_q;
    fl_pc_d    = fl_pc_q;
    inst_buf_d = inst_buf_q;

    case (state_q)
      ST_REQ: begin
        if (!imem_ack) begin
          // The address must not change until ack, so redirects are only recorded.
          if (flush) begin
            pend_fl_d = 1'b1;
            fl_pc_d   = new_pc;
            pend_br_d = 1'b0;
          end else if (pend_fl_q) begin
            pend_br_d = 1'b0;
          end else if (br_q) begin
            pend_br_d = 1'b1;
            br_pc_d   = branch_target_i;
          end
        end else if (discard) begin
          pc_d      = flush ? new_pc : fl_pc_q;
          pend_fl_d = 1'b0;
          pend_br_d = 1'b0;
        end else if (!stall[0]) begin
          pc_d      = pc_next;
          pend_br_d = 1'b0;
        end else begin
          inst_buf_d = imem_rdata;
          state_d    = ST_BUF;
          if (br_q) begin
            pend_br_d = 1'b1;
            br_pc_d   = branch_target_i;
          end
        end
      end

      ST_BUF: begin
        if (flush) begin
          pc_d      = new_pc;
          pend_br_d = 1'b0;
          state_d   = ST_REQ;
        end else if (!stall[0]) begin
          pc_d      = pc_next;
          pend_br_d = 1'b0;
          state_d   = ST_REQ;
        end else if (br_q) begin
          pend_br_d = 1'b1;
          br_pc_d   = branch_target_i;
        end
      end

      default: begin
        state_d   = ST_REQ;
        pc_d      = RESET_PC;
        pend_br_d = 1'b0;
        pend_fl_d = 1'b0;
      end
    endcase
  end

  always_comb begin
    imem_req    = 1'b0;
    imem_addr   = 32'h0;
    if_pc_o     = 32'h0;
    if_inst_o   = 32'h0;
    stallreq_if = 1'b0;
    case (state_q)
      ST_REQ: begin
        imem_req    = 1'b1;
        imem_addr   = pc_q;
        if_pc_o     = pc_q;
        if_inst_o   = (imem_ack && !discard) ? imem_rdata : 32'h0;
        stallreq_if = !(imem_ack && !discard);
      end
      ST_BUF: begin
        imem_addr = pc_q;
        if_pc_o   = pc_q;
        if_inst_o = inst_buf_q;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments only, so every flop
    // samples pre-edge values regardless of block ordering.
    if (rst == RST_ENABLE) begin
      state_q    <= ST_RST;
      pc_q       <= RESET_PC;
      pend_br_q  <= 1'b0;
      br_pc_q    <= 32'h0;
      pend_fl_q  <= 1'b0;
      fl_pc_q    <= 32'h0;
      inst_buf_q <= 32'h0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      pend_br_q  <= pend_br_d;
      br_pc_q    <= br_pc_d;
      pend_fl_q  <= pend_fl_d;
      fl_pc_q    <= fl_pc_d;
      inst_buf_q <= inst_buf_d;
    end
  end

endmodule
